// File: rtl/load_store_unit.sv
// Load/store unit: computes effective addresses, checks access legality and
// alignment, drives a single-outstanding request to data memory, and returns
// load results for writeback and operand forwarding.
//
// Memory handshake: dmem_req is a registered request held high, with
// dmem_addr/dmem_we/dmem_be/dmem_wdata frozen, from the cycle after capture
// until the cycle in which dmem_ack is sampled high; dmem_rdata is consumed on
// that same edge. dmem_ack is ignored whenever no request is outstanding.
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int SYS_REGS_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                opcode_in,
  input  logic [2:0]                funct3_in,
  input  logic [XLEN-1:0]           rs1_data_in,
  input  logic [XLEN-1:0]           rs2_data_in,
  input  logic [XLEN-1:0]           imm_i_data_in,
  input  logic [XLEN-1:0]           imm_s_data_in,
  input  logic [SYS_REGS_WIDTH-1:0] rd_addr_in,
  output logic                      halt_out,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [XLEN-1:0]           dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic                      wb_valid_out,
  output logic [SYS_REGS_WIDTH-1:0] wb_rd_addr_out,
  output logic [XLEN-1:0]           wb_data_out,
  output logic [SYS_REGS_WIDTH-1:0] bypass_rd_addr,
  output logic [XLEN-1:0]           bypass_rd_data,
  output logic                      fault_out,
  output logic [1:0]                state_dbg
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Decode of the instruction currently offered by operand fetch
  logic            is_mem;
  logic            is_store;
  logic [XLEN-1:0] eff_addr;
  logic            legal;
  logic            misaligned;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;

  // Attributes of the captured access needed when the read data returns
  logic [1:0]                addr_lo_q;
  logic [2:0]                funct3_q;
  logic [SYS_REGS_WIDTH-1:0] rd_q;
  logic                      store_q;

  // Load data after lane selection and extension
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_data;

  assign state_dbg = state;

  // Upstream stalls while a memory op is in flight; it may advance in DONE
  assign halt_out = is_mem && (state != DONE);

  // Decode, address generation, legality/alignment and store lane formatting
  always_comb begin
    is_store   = (opcode_in == OP_STORE);
    is_mem     = (opcode_in == OP_LOAD) || is_store;
    eff_addr   = rs1_data_in + (is_store ? imm_s_data_in : imm_i_data_in);
    legal      = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = rs2_data_in;

    if (is_store) begin
      legal = funct3_in inside {3'b000, 3'b001, 3'b010};
    end else begin
      legal = funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end

    // funct3[1:0] gives the access size for every legal encoding
    case (funct3_in[1:0])
      2'b00: begin
        be_next    = 4'b0001 << eff_addr[1:0];
        wdata_next = {(XLEN/8){rs2_data_in[7:0]}};
      end
      2'b01: begin
        misaligned = eff_addr[0];
        be_next    = 4'b0011 << eff_addr[1:0];
        wdata_next = {(XLEN/16){rs2_data_in[15:0]}};
      end
      default: begin
        misaligned = |eff_addr[1:0];
        be_next    = 4'b1111;
        wdata_next = rs2_data_in;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned read word
  always_comb begin
    lane = dmem_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  // Access FSM with all memory, writeback, forwarding and fault outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      wb_valid_out   <= 1'b0;
      wb_rd_addr_out <= '0;
      wb_data_out    <= '0;
      bypass_rd_addr <= '0;
      bypass_rd_data <= '0;
      fault_out      <= 1'b0;
      addr_lo_q      <= '0;
      funct3_q       <= '0;
      rd_q           <= '0;
      store_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            addr_lo_q <= eff_addr[1:0];
            funct3_q  <= funct3_in;
            rd_q      <= rd_addr_in;
            store_q   <= is_store;
            if (legal && !misaligned) begin
              state      <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= eff_addr;
              dmem_be    <= be_next;
              dmem_wdata <= wdata_next;
            end else begin
              // Faulting accesses never reach memory; DONE carries the pulse
              state     <= DONE;
              fault_out <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            // x0 is never written, so a load to rd=0 produces no writeback
            if (!store_q && (rd_q != '0)) begin
              wb_valid_out   <= 1'b1;
              wb_rd_addr_out <= rd_q;
              wb_data_out    <= load_data;
              bypass_rd_addr <= rd_q;
              bypass_rd_data <= load_data;
            end
          end
        end
        DONE: begin
          state          <= IDLE;
          wb_valid_out   <= 1'b0;
          wb_rd_addr_out <= '0;
          wb_data_out    <= '0;
          bypass_rd_addr <= '0;
          bypass_rd_data <= '0;
          fault_out      <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios from the block's usage notes
// plus randomized loads/stores against a byte-addressed memory model.
module tb_load_store_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_NOP   = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] rs1_data_in, rs2_data_in, imm_i_data_in, imm_s_data_in;
  logic [4:0]  rd_addr_in;
  logic        halt_out, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid_out, fault_out;
  logic [4:0]  wb_rd_addr_out, bypass_rd_addr;
  logic [31:0] wb_data_out, bypass_rd_data;
  logic [1:0]  state_dbg;

  load_store_unit #(.XLEN(32), .SYS_REGS_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .opcode_in(opcode_in), .funct3_in(funct3_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .imm_i_data_in(imm_i_data_in), .imm_s_data_in(imm_s_data_in),
    .rd_addr_in(rd_addr_in), .halt_out(halt_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid_out(wb_valid_out), .wb_rd_addr_out(wb_rd_addr_out),
    .wb_data_out(wb_data_out), .bypass_rd_addr(bypass_rd_addr),
    .bypass_rd_data(bypass_rd_data), .fault_out(fault_out), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory behind the bus (word view) and the reference view (byte view)
  logic [31:0] mem_words [0:63];
  logic [7:0]  ref_bytes [0:255];

  // Observations from the most recent access
  logic        obs_idle_halt, obs_req_in_idle, obs_req_seen, obs_unstable, obs_timeout;
  int          obs_halt_cycles, obs_req_cycles;
  logic [31:0] obs_addr, obs_wdata, obs_wb_data, obs_byp_data;
  logic [3:0]  obs_be;
  logic        obs_we, obs_wb_valid, obs_fault, obs_fault_after, obs_wb_after;
  logic [4:0]  obs_wb_rd, obs_byp_rd;
  logic [31:0] obs_byp_after;

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_fault(input bit st, input logic [2:0] f3, input logic [31:0] addr);
    bit ok;
    ok = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return !ok || ((addr % acc_size(f3)) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be;
    int off;
    off = addr % 4;
    be = '0;
    for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + acc_size(f3));
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = rs2[8*(b % acc_size(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    longint v;
    int sz;
    sz = acc_size(f3);
    v = 0;
    for (int k = 0; k < sz; k++) v += longint'(ref_bytes[(addr + k) & 255]) << (8 * k);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  // ---------------- driver / bus responder ----------------
  // Starts just after a rising edge with the unit idle; ends the same way.
  task automatic run_access(input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] imm_i, input logic [31:0] imm_s,
                            input logic [4:0] rd, input int delay);
    opcode_in = op; funct3_in = f3; rs1_data_in = rs1; rs2_data_in = rs2;
    imm_i_data_in = imm_i; imm_s_data_in = imm_s; rd_addr_in = rd;
    #1;
    obs_idle_halt = halt_out;
    obs_req_in_idle = dmem_req;
    obs_halt_cycles = halt_out ? 1 : 0;
    @(posedge clk); #1;
    obs_req_seen = 0; obs_unstable = 0; obs_req_cycles = 0; obs_timeout = 1;
    obs_wb_valid = 0; obs_fault = 0;
    for (int c = 0; c < 40; c++) begin
      if (!halt_out) begin
        obs_wb_valid = wb_valid_out; obs_wb_rd = wb_rd_addr_out; obs_wb_data = wb_data_out;
        obs_byp_rd = bypass_rd_addr; obs_byp_data = bypass_rd_data; obs_fault = fault_out;
        obs_timeout = 0;
        break;
      end
      obs_halt_cycles++;
      if (dmem_req) begin
        if (!obs_req_seen) begin
          obs_req_seen = 1; obs_addr = dmem_addr; obs_be = dmem_be;
          obs_we = dmem_we; obs_wdata = dmem_wdata;
        end else if (dmem_addr !== obs_addr || dmem_be !== obs_be ||
                     dmem_we !== obs_we || dmem_wdata !== obs_wdata) begin
          obs_unstable = 1;
        end
        if (obs_req_cycles == delay) begin
          dmem_ack = 1'b1;
          dmem_rdata = mem_words[dmem_addr[7:2]];
          if (dmem_we)
            for (int b = 0; b < 4; b++)
              if (dmem_be[b]) mem_words[dmem_addr[7:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
        end
        obs_req_cycles++;
      end else begin
        obs_unstable = 1;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
    end
    n_checks++;
    if (obs_timeout) begin
      n_errors++;
      $display("FAIL access_timeout: no DONE cycle within 40 cycles (op=%b f3=%b)", op, f3);
    end
    opcode_in = OP_NOP;
    @(posedge clk); #1;
    obs_fault_after = fault_out; obs_wb_after = wb_valid_out; obs_byp_after = bypass_rd_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; opcode_in = OP_NOP; funct3_in = '0; rs1_data_in = '0; rs2_data_in = '0;
    imm_i_data_in = '0; imm_s_data_in = '0; rd_addr_in = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({dmem_req, dmem_we, dmem_be} !== 6'b0) begin n_errors++; $display("FAIL reset_req got=%b exp=0", {dmem_req, dmem_we, dmem_be}); end
    n_checks++; if ({dmem_addr, dmem_wdata} !== 64'b0) begin n_errors++; $display("FAIL reset_bus got=%h exp=0", {dmem_addr, dmem_wdata}); end
    n_checks++; if ({wb_valid_out, wb_rd_addr_out, wb_data_out} !== 38'b0) begin n_errors++; $display("FAIL reset_wb got=%h exp=0", {wb_valid_out, wb_rd_addr_out, wb_data_out}); end
    n_checks++; if ({bypass_rd_addr, bypass_rd_data, fault_out, halt_out} !== 39'b0) begin n_errors++; $display("FAIL reset_misc got=%h exp=0", {bypass_rd_addr, bypass_rd_data, fault_out, halt_out}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw_basic;
    mem_words[2] = 32'hDEADBEEF;
    run_access(OP_LOAD, 3'b010, 32'h1000, 32'h0, 32'd8, 32'h77, 5'd5, 0);
    n_checks++; if (obs_idle_halt !== 1'b1 || obs_req_in_idle !== 1'b0) begin n_errors++; $display("FAIL lw_idle got halt=%b req=%b exp halt=1 req=0", obs_idle_halt, obs_req_in_idle); end
    n_checks++; if (obs_addr !== 32'h1008) begin n_errors++; $display("FAIL lw_addr got=%h exp=00001008", obs_addr); end
    n_checks++; if (obs_be !== 4'b1111 || obs_we !== 1'b0) begin n_errors++; $display("FAIL lw_be_we got be=%b we=%b exp be=1111 we=0", obs_be, obs_we); end
    n_checks++; if (obs_halt_cycles != 2) begin n_errors++; $display("FAIL lw_latency got halt_cycles=%0d exp=2", obs_halt_cycles); end
    n_checks++; if (obs_wb_valid !== 1'b1 || obs_wb_rd !== 5'd5 || obs_wb_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lw_wb got v=%b rd=%0d d=%h exp v=1 rd=5 d=deadbeef", obs_wb_valid, obs_wb_rd, obs_wb_data); end
    n_checks++; if (obs_byp_rd !== 5'd5 || obs_byp_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lw_bypass got rd=%0d d=%h exp rd=5 d=deadbeef", obs_byp_rd, obs_byp_data); end
    n_checks++; if (obs_wb_after !== 1'b0 || obs_byp_after !== 32'h0) begin n_errors++; $display("FAIL lw_after got v=%b byp=%h exp v=0 byp=0", obs_wb_after, obs_byp_after); end
  endtask

  task automatic test_lb_lbu;
    mem_words[0] = 32'h80000000;
    run_access(OP_LOAD, 3'b000, 32'h1000, 32'h0, 32'd3, 32'h0, 5'd7, 0);
    n_checks++; if (obs_be !== 4'b1000 || obs_wb_data !== 32'hFFFFFF80) begin n_errors++; $display("FAIL lb_sext got be=%b d=%h exp be=1000 d=ffffff80", obs_be, obs_wb_data); end
    run_access(OP_LOAD, 3'b100, 32'h1000, 32'h0, 32'd3, 32'h0, 5'd7, 1);
    n_checks++; if (obs_wb_valid !== 1'b1 || obs_wb_data !== 32'h00000080) begin n_errors++; $display("FAIL lbu_zext got v=%b d=%h exp v=1 d=00000080", obs_wb_valid, obs_wb_data); end
    mem_words[0] = 32'h8001_7FFF;
    run_access(OP_LOAD, 3'b001, 32'h1000, 32'h0, 32'd2, 32'h0, 5'd8, 0);
    n_checks++; if (obs_be !== 4'b1100 || obs_wb_data !== 32'hFFFF8001) begin n_errors++; $display("FAIL lh_sext got be=%b d=%h exp be=1100 d=ffff8001", obs_be, obs_wb_data); end
    run_access(OP_LOAD, 3'b010, 32'h1000, 32'h0, 32'd0, 32'h0, 5'd0, 0);
    n_checks++; if (obs_req_seen !== 1'b1 || obs_wb_valid !== 1'b0 || obs_byp_data !== 32'h0) begin n_errors++; $display("FAIL lw_x0 got req=%b v=%b byp=%h exp req=1 v=0 byp=0", obs_req_seen, obs_wb_valid, obs_byp_data); end
  endtask

  task automatic test_sh;
    run_access(OP_STORE, 3'b001, 32'h2000, 32'h1234ABCD, 32'h40, 32'd2, 5'd9, 0);
    n_checks++; if (obs_we !== 1'b1 || obs_addr !== 32'h2002) begin n_errors++; $display("FAIL sh_addr got we=%b a=%h exp we=1 a=00002002", obs_we, obs_addr); end
    n_checks++; if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD) begin n_errors++; $display("FAIL sh_lanes got be=%b w=%h exp be=1100 w=abcdabcd", obs_be, obs_wdata); end
    n_checks++; if (obs_wb_valid !== 1'b0 || obs_byp_rd !== 5'd0 || obs_fault !== 1'b0) begin n_errors++; $display("FAIL sh_nowb got v=%b byp_rd=%0d f=%b exp 0/0/0", obs_wb_valid, obs_byp_rd, obs_fault); end
    run_access(OP_STORE, 3'b000, 32'h2000, 32'h000000A5, 32'h0, 32'd1, 5'd0, 2);
    n_checks++; if (obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5A5A5 || obs_unstable) begin n_errors++; $display("FAIL sb_lanes got be=%b w=%h unstable=%b exp be=0010 w=a5a5a5a5 unstable=0", obs_be, obs_wdata, obs_unstable); end
  endtask

  task automatic test_faults;
    run_access(OP_LOAD, 3'b010, 32'h1000, 32'h0, 32'd2, 32'h0, 5'd4, 0);
    n_checks++; if (obs_req_seen !== 1'b0 || obs_halt_cycles != 1) begin n_errors++; $display("FAIL lw_mis_req got req=%b halt_cycles=%0d exp req=0 halt_cycles=1", obs_req_seen, obs_halt_cycles); end
    n_checks++; if (obs_fault !== 1'b1 || obs_fault_after !== 1'b0 || obs_wb_valid !== 1'b0) begin n_errors++; $display("FAIL lw_mis_fault got f=%b after=%b v=%b exp 1/0/0", obs_fault, obs_fault_after, obs_wb_valid); end
    run_access(OP_LOAD, 3'b011, 32'h1000, 32'h0, 32'd0, 32'h0, 5'd4, 0);
    n_checks++; if (obs_req_seen !== 1'b0 || obs_halt_cycles != 1 || obs_fault !== 1'b1 || obs_wb_valid !== 1'b0) begin n_errors++; $display("FAIL ld_f3_011 got req=%b hc=%0d f=%b v=%b exp 0/1/1/0", obs_req_seen, obs_halt_cycles, obs_fault, obs_wb_valid); end
    run_access(OP_STORE, 3'b100, 32'h1000, 32'h0, 32'd0, 32'd0, 5'd0, 0);
    n_checks++; if (obs_req_seen !== 1'b0 || obs_fault !== 1'b1) begin n_errors++; $display("FAIL st_f3_100 got req=%b f=%b exp req=0 f=1", obs_req_seen, obs_fault); end
    run_access(OP_LOAD, 3'b101, 32'h1000, 32'h0, 32'd1, 32'h0, 5'd4, 0);
    n_checks++; if (obs_req_seen !== 1'b0 || obs_fault !== 1'b1) begin n_errors++; $display("FAIL lhu_odd got req=%b f=%b exp req=0 f=1", obs_req_seen, obs_fault); end
  endtask

  task automatic test_delayed_ack;
    mem_words[1] = 32'h0BADF00D;
    run_access(OP_LOAD, 3'b010, 32'h3000, 32'h0, 32'd4, 32'h0, 5'd3, 3);
    n_checks++; if (obs_unstable !== 1'b0 || obs_req_cycles != 4 || obs_halt_cycles != 5) begin n_errors++; $display("FAIL delay_stable got unstable=%b req_cycles=%0d halt_cycles=%0d exp 0/4/5", obs_unstable, obs_req_cycles, obs_halt_cycles); end
    n_checks++; if (obs_wb_valid !== 1'b1 || obs_wb_data !== 32'h0BADF00D) begin n_errors++; $display("FAIL delay_wb got v=%b d=%h exp v=1 d=0badf00d", obs_wb_valid, obs_wb_data); end
  endtask

  task automatic test_reset_in_req;
    bit bad;
    opcode_in = OP_LOAD; funct3_in = 3'b010; rs1_data_in = 32'h1000; imm_i_data_in = 32'd4; rd_addr_in = 5'd6;
    @(posedge clk); #1;
    n_checks++; if (dmem_req !== 1'b1) begin n_errors++; $display("FAIL rstreq_pre got req=%b exp 1", dmem_req); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (dmem_req !== 1'b0 || dmem_addr !== 32'h0) begin n_errors++; $display("FAIL rstreq_drop got req=%b a=%h exp req=0 a=0", dmem_req, dmem_addr); end
    opcode_in = OP_NOP;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (wb_valid_out !== 1'b0 || dmem_req !== 1'b0 || fault_out !== 1'b0 || halt_out !== 1'b0) bad = 1;
      if (c == 1) dmem_ack = 1'b0;
    end
    n_checks++; if (bad) begin n_errors++; $display("FAIL late_ack got a reaction (wb/req/fault/halt) exp none"); end
  endtask

  task automatic test_wrap;
    mem_words[1] = 32'hCAFE0001;
    run_access(OP_LOAD, 3'b010, 32'hFFFFFFFC, 32'h0, 32'd8, 32'h0, 5'd12, 0);
    n_checks++; if (obs_addr !== 32'h00000004 || obs_wb_data !== 32'hCAFE0001) begin n_errors++; $display("FAIL addr_wrap got a=%h d=%h exp a=00000004 d=cafe0001", obs_addr, obs_wb_data); end
  endtask

  task automatic test_random;
    bit st, exp_fault, exp_wb;
    logic [2:0] f3;
    logic [31:0] rs1, rs2, imm, junk, addr, exp_d;
    logic [4:0] rd;
    int off;
    for (int a = 0; a < 256; a++) ref_bytes[a] = 8'($urandom);
    for (int w = 0; w < 64; w++) mem_words[w] = {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    for (int it = 0; it < 80; it++) begin
      st  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : ((f3 == 3'd3 || f3 > 3'd5) ? 3'd4 : f3);
      rs1 = 32'($urandom_range(64, 191));
      off = int'($urandom_range(0, 128)) - 64;
      imm = 32'(off);
      junk = $urandom;
      rs2 = $urandom;
      rd  = 5'($urandom_range(0, 31));
      if (it % 8 == 0) rd = 5'd0;
      addr = rs1 + imm;
      exp_fault = model_fault(st, f3, addr);
      exp_wb = !st && !exp_fault && (rd != 5'd0);
      exp_d = (!st && !exp_fault) ? model_load(f3, addr) : 32'h0;
      run_access(st ? OP_STORE : OP_LOAD, f3, rs1, rs2, st ? junk : imm, st ? imm : junk, rd, int'($urandom_range(0, 3)));
      n_checks++; if (obs_fault !== exp_fault || obs_req_seen !== !exp_fault) begin n_errors++; $display("FAIL rnd_fault it=%0d got f=%b req=%b exp f=%b req=%b", it, obs_fault, obs_req_seen, exp_fault, !exp_fault); end
      n_checks++; if (obs_wb_valid !== exp_wb) begin n_errors++; $display("FAIL rnd_wbv it=%0d got %b exp %b", it, obs_wb_valid, exp_wb); end
      if (!exp_fault) begin
        n_checks++; if (obs_addr !== addr || obs_be !== model_be(f3, addr) || obs_we !== st) begin n_errors++; $display("FAIL rnd_bus it=%0d got a=%h be=%b we=%b exp a=%h be=%b we=%b", it, obs_addr, obs_be, obs_we, addr, model_be(f3, addr), st); end
      end
      if (!exp_fault && st) begin
        n_checks++; if (obs_wdata !== model_wdata(f3, rs2)) begin n_errors++; $display("FAIL rnd_wdata it=%0d got %h exp %h", it, obs_wdata, model_wdata(f3, rs2)); end
        for (int k = 0; k < acc_size(f3); k++) ref_bytes[(addr + k) & 255] = rs2[8*k +: 8];
      end
      if (exp_wb) begin
        n_checks++; if (obs_wb_data !== exp_d || obs_wb_rd !== rd || obs_byp_data !== exp_d || obs_byp_rd !== rd) begin n_errors++; $display("FAIL rnd_load it=%0d got d=%h rd=%0d byp=%h/%0d exp d=%h rd=%0d", it, obs_wb_data, obs_wb_rd, obs_byp_data, obs_byp_rd, exp_d, rd); end
      end else begin
        n_checks++; if (obs_byp_rd !== 5'd0 || obs_byp_data !== 32'h0) begin n_errors++; $display("FAIL rnd_byp0 it=%0d got %0d/%h exp 0/0", it, obs_byp_rd, obs_byp_data); end
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset;
    test_lw_basic;
    test_lb_lbu;
    test_sh;
    test_faults;
    test_delayed_ack;
    test_reset_in_req;
    test_wrap;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
